// File: rtl/definition_param_rxside.sv
// Receive-side parameter latch: assembles 15-byte parameter packets, verifies the XOR checksum,
// and commits a good packet to the outputs on the next vsync rising edge.
module definition_param_rxside #(
    parameter logic [7:0] P_HEADER  = 8'hA5,
    parameter int         P_TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_vsync,
    output logic [10:0] o_gaze_x,
    output logic [10:0] o_gaze_y,
    output logic [23:0] o_tres_1,
    output logic [23:0] o_tres_2,
    output logic [23:0] o_tres_3,
    output logic        o_update,
    output logic        o_pending,
    output logic [7:0]  o_err_cnt
);
    localparam int LP_IDLE_W = $clog2(P_TIMEOUT + 1);

    localparam logic [1:0] S_HUNT    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    logic [1:0]           r_state;
    logic [3:0]           r_idx;
    logic [7:0]           r_xor;
    logic [LP_IDLE_W-1:0] r_idle;
    logic [10:0]          r_as_gx, r_as_gy;
    logic [23:0]          r_as_t1, r_as_t2, r_as_t3;
    logic [10:0]          r_sh_gx, r_sh_gy;
    logic [23:0]          r_sh_t1, r_sh_t2, r_sh_t3;
    logic                 r_pending;
    logic [7:0]           r_err_cnt;
    logic [1:0]           r_vs_edge;
    logic                 r_update;
    logic [10:0]          r_gaze_x, r_gaze_y;
    logic [23:0]          r_tres_1, r_tres_2, r_tres_3;

    logic w_commit, w_load, w_accept, w_bad_cs, w_timeout;

    assign w_commit  = (r_vs_edge == 2'b01);
    assign w_load    = w_commit && r_pending;
    assign w_accept  = (r_state == S_CHECK) && i_valid && (i_data == r_xor);
    assign w_bad_cs  = (r_state == S_CHECK) && i_valid && (i_data != r_xor);
    assign w_timeout = (r_state != S_HUNT) && !i_valid &&
                       (r_idle == LP_IDLE_W'(P_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_HUNT;
            r_idx   <= '0;
            r_xor   <= '0;
            r_idle  <= '0;
        end else begin
            case (r_state)
                S_HUNT: begin
                    if (i_valid && (i_data == P_HEADER)) begin
                        r_state <= S_PAYLOAD;
                        r_idx   <= '0;
                        r_xor   <= '0;
                        r_idle  <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (i_valid) begin
                        r_xor  <= r_xor ^ i_data;
                        r_idle <= '0;
                        if (r_idx == 4'd12) r_state <= S_CHECK;
                        else                r_idx   <= r_idx + 4'd1;
                    end else if (w_timeout) begin
                        r_state <= S_HUNT;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (i_valid || w_timeout) r_state <= S_HUNT;
                    else                      r_idle  <= r_idle + 1'b1;
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    // Payload bytes land big-endian; upper five bits of each gaze word are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_as_gx <= '0;
            r_as_gy <= '0;
            r_as_t1 <= '0;
            r_as_t2 <= '0;
            r_as_t3 <= '0;
        end else if ((r_state == S_PAYLOAD) && i_valid) begin
            case (r_idx)
                4'd0:    r_as_gx[10:8]  <= i_data[2:0];
                4'd1:    r_as_gx[7:0]   <= i_data;
                4'd2:    r_as_gy[10:8]  <= i_data[2:0];
                4'd3:    r_as_gy[7:0]   <= i_data;
                4'd4:    r_as_t1[23:16] <= i_data;
                4'd5:    r_as_t1[15:8]  <= i_data;
                4'd6:    r_as_t1[7:0]   <= i_data;
                4'd7:    r_as_t2[23:16] <= i_data;
                4'd8:    r_as_t2[15:8]  <= i_data;
                4'd9:    r_as_t2[7:0]   <= i_data;
                4'd10:   r_as_t3[23:16] <= i_data;
                4'd11:   r_as_t3[15:8]  <= i_data;
                4'd12:   r_as_t3[7:0]   <= i_data;
                default: ;
            endcase
        end
    end

    // Outputs read the old shadow before a same-cycle accept overwrites it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_gx   <= '0;
            r_sh_gy   <= '0;
            r_sh_t1   <= '0;
            r_sh_t2   <= '0;
            r_sh_t3   <= '0;
            r_pending <= 1'b0;
            r_gaze_x  <= '0;
            r_gaze_y  <= '0;
            r_tres_1  <= '0;
            r_tres_2  <= '0;
            r_tres_3  <= '0;
            r_update  <= 1'b0;
            r_vs_edge <= 2'b00;
        end else begin
            r_vs_edge <= {r_vs_edge[0], i_vsync};
            r_update  <= w_load;
            if (w_load) begin
                r_gaze_x <= r_sh_gx;
                r_gaze_y <= r_sh_gy;
                r_tres_1 <= r_sh_t1;
                r_tres_2 <= r_sh_t2;
                r_tres_3 <= r_sh_t3;
            end
            if (w_accept) begin
                r_sh_gx   <= r_as_gx;
                r_sh_gy   <= r_as_gy;
                r_sh_t1   <= r_as_t1;
                r_sh_t2   <= r_as_t2;
                r_sh_t3   <= r_as_t3;
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if ((w_bad_cs || w_timeout) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_gaze_x  = r_gaze_x;
    assign o_gaze_y  = r_gaze_y;
    assign o_tres_1  = r_tres_1;
    assign o_tres_2  = r_tres_2;
    assign o_tres_3  = r_tres_3;
    assign o_update  = r_update;
    assign o_pending = r_pending;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: doc/definition_param_rxside.md
Name: definition_param_rxside

Overview:
- Receive-side counterpart of the frame-aligned parameter latch on the TX side.
- Accepts a byte stream carrying one parameter packet per frame: gaze X/Y plus three 24-bit thresholds.
- Checks header and checksum, holds a good packet in a shadow bank, and transfers it to the outputs on the next vsync rising edge, so downstream sees parameters change only at frame boundaries.

Parameters:
- P_HEADER, 8'hA5, packet start byte.
- P_TIMEOUT, 256, maximum idle cycles between consecutive bytes inside a packet before abort.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data  input  8  received byte.
- i_valid  input  1  i_data valid this cycle.
- i_vsync  input  1  frame sync, level; rising edge commits parameters.
- o_gaze_x  output  11  committed gaze X.
- o_gaze_y  output  11  committed gaze Y.
- o_tres_1  output  24  committed threshold 1.
- o_tres_2  output  24  committed threshold 2.
- o_tres_3  output  24  committed threshold 3.
- o_update  output  1  one-cycle pulse when the outputs are loaded.
- o_pending  output  1  a checked packet waits in the shadow bank.
- o_err_cnt  output  8  saturating count of checksum errors and timeouts.

Behaviour:
- Reset (i_rst_n low, asynchronous): all outputs, shadow bank, pending flag, error counter, FSM and vsync edge flops go to 0; FSM enters HUNT.
- Packet format: 15 bytes, big-endian.
  - Byte 0: P_HEADER.
  - Bytes 1-2: gaze_x; bits [10:0] used, upper 5 bits ignored.
  - Bytes 3-4: gaze_y; same rule.
  - Bytes 5-7: tres_1. Bytes 8-10: tres_2. Bytes 11-13: tres_3.
  - Byte 14: checksum, the XOR of bytes 1-13.
- FSM:
  - HUNT: on i_valid with i_data==P_HEADER, go to PAYLOAD; clear byte index (0..12), running XOR and idle counter. Any other byte is discarded silently.
  - PAYLOAD: each i_valid byte goes into the assembly register at its index and XORs into the running checksum. After index 12, go to CHECK. A header value inside the payload is ordinary data.
  - CHECK: the next i_valid byte is compared against the running XOR.
    - Match: assembly register copied to shadow bank, pending set to 1.
    - Mismatch: o_err_cnt increments; shadow and pending are unchanged.
    - Either way, go to HUNT.
  - Timeout: in PAYLOAD or CHECK, if i_valid stays low for P_TIMEOUT consecutive cycles, abort to HUNT and increment o_err_cnt. The idle counter resets on every valid byte.
- o_err_cnt saturates at 255; it does not wrap.
- Vsync edge detection:
  - Two flops: edge[0]<=i_vsync, edge[1]<=edge[0]. Commit condition is edge==2'b01.
  - If i_vsync is first sampled high at clock edge k, the outputs load at edge k+1.
  - No commit on a falling edge or on a held level.
- Commit (edge==01 and pending==1): all five outputs load from the shadow bank; pending clears; o_update pulses high for exactly one cycle.
- Commit with pending==0: outputs hold; no o_update pulse.
- Same-cycle packet accept and commit:
  - The outputs take the shadow contents from before this cycle, only if pending was already 1.
  - The newly accepted packet overwrites the shadow and pending ends at 1.
  - A packet never reaches the outputs in the cycle it is accepted.
- A second good packet before vsync overwrites the shadow; the last good packet wins.
- Outputs change only at commit or reset.

Test Plan:
1. Reset, then vsync pulses with no packet -> outputs stay 0, o_update never asserts, o_err_cnt=0.
2. Send A5 01 23 00 FF 11 22 33 44 55 66 77 88 99 CC, then raise vsync -> o_pending=1 after the last byte. One cycle after vsync is first sampled high: o_gaze_x=0x123, o_gaze_y=0x0FF, o_tres_1=0x112233, o_tres_2=0x445566, o_tres_3=0x778899, o_update pulses for 1 cycle, o_pending=0.
3. Same packet with checksum 0xCD -> o_err_cnt=1, o_pending stays 0, outputs unchanged after vsync.
4. Stop sending after byte 6 for 256 cycles, then send a full good packet -> o_err_cnt=1, and the good packet commits on the next vsync.
5. Two good packets before one vsync (gaze_x 0x123, then 0x7FF) -> o_gaze_x=0x7FF after commit. Separately, a packet accepted in the same cycle as the commit edge leaves the outputs at the previous pending values and o_pending=1.
6. Assert i_rst_n low mid-packet (after byte 8) with committed values present -> outputs go to 0 immediately without a clock edge. After release, stray payload bytes are ignored until the next A5.
